// File: rtl/rr_mux_8x1.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_8x1
//  Description : Eight-lane to one-lane round-robin collector. One source lane
//                is granted per cycle, and the granted word goes into a single
//                registered output stage. The word carries a 3-bit lane tag so
//                that a downstream 1x8 demux can route it back out.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1          rising-edge clock
//    rst        in   1          synchronous active-high reset
//    in_valid   in   8          per-lane valid, bit k = lane k
//    in_data    in   8*DATA_W   lane k word at [k*DATA_W +: DATA_W]
//    in_ready   out  8          per-lane accept, at most one bit set
//    out_valid  out  1          output register holds a word
//    out_data   out  DATA_W     forwarded word
//    out_sel    out  3          lane index of out_data
//    out_ready  in   1          downstream takes the word when valid & ready
// ============================================================================
module rr_mux_8x1 #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_valid,
    input  logic [8*DATA_W-1:0]   in_data,
    output logic [7:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [2:0]            out_sel,
    input  logic                  out_ready
);

    localparam int         c_LANES = 8;
    localparam logic [2:0] c_ZERO  = 3'd0;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic [2:0]           r_out_sel;
    logic [2:0]           r_ptr;      // lane with highest priority this cycle

    // ------------------------------------------------------------------
    // Combinational decisions
    // ------------------------------------------------------------------
    logic                 w_load;     // output register may take a new word
    logic                 w_found;    // some lane is requesting
    logic [2:0]           w_grant;    // first requesting lane at or after r_ptr
    logic                 w_xfer;     // a lane hands over its word this cycle
    logic [DATA_W-1:0]    w_grant_data;
    logic [2:0]           w_ptr_next;

    // The register frees up when it is empty or being drained this cycle,
    // which lets a pop and an accept share a cycle without a bubble.
    assign w_load = !rst && (!r_out_valid || out_ready);

    // Rotating priority search. The 3-bit index wraps 7->0 on its own, so
    // scanning offsets 0..7 from r_ptr visits every lane exactly once.
    always_comb begin
        logic [2:0] v_idx;
        w_found = 1'b0;
        w_grant = c_ZERO;
        v_idx   = c_ZERO;
        for (int i = 0; i < c_LANES; i++) begin
            v_idx = r_ptr + 3'(i);
            if (!w_found && in_valid[v_idx]) begin
                w_found = 1'b1;
                w_grant = v_idx;
            end
        end
    end

    assign w_xfer       = w_load && w_found;
    assign w_grant_data = in_data[w_grant*DATA_W +: DATA_W];
    // Grant of lane 7 naturally wraps the pointer back to lane 0.
    assign w_ptr_next   = w_grant + 3'd1;

    // One-hot accept. Driven only from valids, pointer and output-stage
    // state, so there is no path from in_data to in_ready.
    generate
        for (genvar k = 0; k < c_LANES; k++) begin : g_ready
            assign in_ready[k] = w_xfer && (w_grant == 3'(k));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= c_ZERO;
            r_ptr       <= c_ZERO;
        end else if (w_load) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_sel   <= w_grant;
                r_ptr       <= w_ptr_next;
            end else begin
                // Drained with nothing to replace it: data/tag keep their
                // last values, only the valid flag drops.
                r_out_valid <= 1'b0;
            end
        end
        // Stall (valid && !out_ready): everything holds.
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_8x1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_mux_8x1
//  Description : Self-checking bench for rr_mux_8x1 (DATA_W = 8). A table of
//                sequential cycle vectors drives the block, followed by
//                hand-written sequences for full contention and reset during
//                a stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_8x1;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst;
    logic [7:0]          in_valid;
    logic [8*DATA_W-1:0] in_data;
    logic [7:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          out_sel;
    logic                out_ready;

    int n_cmp;
    int n_bad;

    rr_mux_8x1 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [7:0]  iv;
        logic [63:0] data;
        logic        ordy;
        logic [7:0]  exp_ready;   // checked before the edge
        logic        exp_ov;      // checked after the edge
        logic [2:0]  exp_sel;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[32];
    int   nv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle: check combinational in_ready before the edge,
    // registered outputs shortly after it.
    task automatic step(input string tag, input logic r, input logic [7:0] iv,
                        input logic [63:0] d, input logic ordy,
                        input logic [7:0] e_rdy, input logic e_ov,
                        input logic [2:0] e_sel, input logic [7:0] e_data);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(e_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
        chk({tag, ".out_sel"}, 64'(out_sel), 64'(e_sel));
        chk({tag, ".out_data"}, 64'(out_data), 64'(e_data));
    endtask

    localparam logic [63:0] D  = 64'h1716151413121110;
    localparam logic [63:0] D5 = 64'h1716A51413121110;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nv    = 0;
        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

        // rst, iv, data, ordy, exp_ready, exp_ov, exp_sel, exp_data
        // Reset then idle
        vecs[nv++] = '{1'b1, 8'h00, D,  1'b0, 8'h00, 1'b0, 3'd0, 8'h00};
        vecs[nv++] = '{1'b1, 8'hFF, D,  1'b1, 8'h00, 1'b0, 3'd0, 8'h00};
        for (int i = 0; i < 5; i++)
            vecs[nv++] = '{1'b0, 8'h00, D, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00};
        // Single lane 5 -> ptr 6
        vecs[nv++] = '{1'b0, 8'h20, D5, 1'b1, 8'h20, 1'b1, 3'd5, 8'hA5};
        vecs[nv++] = '{1'b0, 8'h00, D5, 1'b1, 8'h00, 1'b0, 3'd5, 8'hA5};
        // ptr 6: lanes 5,6 -> lane 6 wins, ptr 7
        vecs[nv++] = '{1'b0, 8'h60, D,  1'b1, 8'h40, 1'b1, 3'd6, 8'h16};
        // ptr 7, lanes 1,2: skip 7 and 0 -> lane 1, ptr 2
        vecs[nv++] = '{1'b0, 8'h06, D,  1'b1, 8'h02, 1'b1, 3'd1, 8'h11};
        vecs[nv++] = '{1'b0, 8'h06, D,  1'b1, 8'h04, 1'b1, 3'd2, 8'h12};
        vecs[nv++] = '{1'b0, 8'h00, D,  1'b1, 8'h00, 1'b0, 3'd2, 8'h12};
        // Backpressure: reset, lanes 0,3, out_ready low 3 cycles after grant
        vecs[nv++] = '{1'b1, 8'h00, D,  1'b1, 8'h00, 1'b0, 3'd0, 8'h00};
        vecs[nv++] = '{1'b0, 8'h09, D,  1'b0, 8'h01, 1'b1, 3'd0, 8'h10};
        for (int i = 0; i < 3; i++)
            vecs[nv++] = '{1'b0, 8'h08, D, 1'b0, 8'h00, 1'b1, 3'd0, 8'h10};
        vecs[nv++] = '{1'b0, 8'h08, D,  1'b1, 8'h08, 1'b1, 3'd3, 8'h13};
        vecs[nv++] = '{1'b0, 8'h00, D,  1'b1, 8'h00, 1'b0, 3'd3, 8'h13};

        @(posedge clk);
        #1;
        for (int i = 0; i < nv; i++)
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].iv, vecs[i].data,
                 vecs[i].ordy, vecs[i].exp_ready, vecs[i].exp_ov,
                 vecs[i].exp_sel, vecs[i].exp_data);

        // Full contention from ptr 0: 0..7,0..7 back to back
        step("fc_rst", 1'b1, 8'h00, D, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 16; i++)
            step($sformatf("fc%0d", i), 1'b0, 8'hFF, D, 1'b1,
                 8'(1 << (i % 8)), 1'b1, 3'(i % 8), 8'(8'h10 + (i % 8)));

        // Reset during a stall holding lane 4's word
        step("rs_g4",    1'b0, 8'h10, D, 1'b1, 8'h10, 1'b1, 3'd4, 8'h14);
        step("rs_stall", 1'b0, 8'hFF, D, 1'b0, 8'h00, 1'b1, 3'd4, 8'h14);
        step("rs_rst",   1'b1, 8'hFF, D, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
        step("rs_first", 1'b0, 8'hFF, D, 1'b1, 8'h01, 1'b1, 3'd0, 8'h10);
        step("rs_next",  1'b0, 8'hFF, D, 1'b1, 8'h02, 1'b1, 3'd1, 8'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_mux_8x1.md
Name: rr_mux_8x1

Overview:
- Eight-lane to one-lane round-robin collector; the merge side of our 1-to-8 demux fabric.
- Each of 8 source lanes presents valid/data.
- The block picks one lane per cycle fairly and forwards its word on a single registered output.
- The output carries a 3-bit lane tag, so a downstream 1x8 demux can re-route the word using the tag as its select.

Parameters:
- DATA_W, 8, width of each lane's data word.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  8  per-lane valid; bit k belongs to lane k.
- in_data  input  8*DATA_W  lane k word at bits [k*DATA_W +: DATA_W].
- in_ready  output  8  per-lane accept; at most one bit high per cycle.
- out_valid  output  1  registered output holds a word.
- out_data  output  DATA_W  registered forwarded word.
- out_sel  output  3  registered lane index of out_data.
- out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.

Behaviour:
- **Reset** (rst high at a clk edge):
  - out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
  - in_ready=0 for every cycle rst is high.
  - Reset mid-transfer discards the held word, with no acceptance reported to any lane.
- **Load condition:**
  - load = !rst && (!out_valid || out_ready).
  - The output register is refilled only when load is true.
- **Arbitration** (combinational, every cycle):
  - Search in_valid from lane ptr upward, wrapping 7→0.
  - The first set bit is the grant g.
  - If no bit is set, there is no grant.
- **in_ready:**
  - in_ready[g] = load && grant exists; all other bits are 0.
  - in_ready never depends on out_valid of the same lane word.
  - There are no combinational paths from in_data to in_ready.
- **Transfer:**
  - A lane transfers when in_valid[k] && in_ready[k].
  - At the next edge: out_data <= word of lane g, out_sel <= g, out_valid <= 1, ptr <= (g+1) mod 8.
- **No transfer, load true:**
  - out_valid <= 0; ptr unchanged; out_data and out_sel hold their old values.
- **Stall** (out_valid && !out_ready): out_valid, out_data, out_sel and ptr all hold, and all in_ready are 0.
- **Throughput and latency:**
  - One word per cycle sustained when out_ready stays high.
  - Latency is 1 cycle from lane acceptance to out_valid.
- **Fairness:**
  - With all 8 lanes continuously valid and out_ready high, grants run 0,1,...,7,0,...
  - No lane waits more than 7 grants once its valid is high.
- **Wrap-around:** a grant of lane 7 sets ptr=0.
- **Simultaneous events:**
  - The downstream pop and the upstream accept occur in the same cycle with no bubble.
  - Lanes that drop in_valid without being granted lose nothing; the block holds no per-lane state.
- **Source rule:**
  - Sources must hold in_valid/in_data stable until accepted.
  - The block does not check this.

Test Plan:
1. Reset then idle: rst high 2 cycles, then in_valid=0 for 5 cycles → out_valid=0, out_sel=0, out_data=0, in_ready=8'h00 throughout.
2. Single lane, DATA_W=8: in_valid=8'h20, lane5 data=8'hA5, out_ready=1 → in_ready=8'h20 that cycle; next cycle out_valid=1, out_sel=3'd5, out_data=8'hA5; ptr becomes 6.
3. Full contention: in_valid=8'hFF, lane k data=8'h10+k, out_ready=1, 16 cycles → out_sel sequence 0..7,0..7; out_data 8'h10..8'h17 repeating; no bubbles.
4. Backpressure: in_valid=8'h09 (lanes 0,3), out_ready=0 for 3 cycles after the first grant.
   - Lane 0 word is held, with out_sel=0 stable and in_ready=0.
   - When out_ready rises, lane 3 is accepted in that same cycle; the next cycle shows out_sel=3.
5. Wrap and skip: ptr=7 after a lane-6 grant, then in_valid=8'h06 → lane 1 is granted (7 and 0 are skipped), out_sel=1, ptr=2.
6. Reset mid-stall: out_valid=1 with out_sel=4 and out_ready=0, assert rst for 1 cycle → out_valid=0, ptr=0.
   - With in_valid=8'hFF afterwards, the first grant goes to lane 0.
